// File: rtl/hazard_if.sv
// Signal bundle between the OTTER pipeline datapath and its hazard/sequencing controller.
// The datapath drives hazard sources (master); the controller drives stage enables/bubbles (slave).
interface hazard_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_use_rs1;
  logic             if_id_use_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_memread;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             dmem_busy;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2, id_ex_rd, id_ex_memread,
           ex_branch_taken, imem_ready, dmem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2, id_ex_rd, id_ex_memread,
           ex_branch_taken, imem_ready, dmem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_flush, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stage enable/bubble sequencing for the 5-stage OTTER pipeline: load-use stalls, redirects,
// IMEM/DMEM waits, stale-fetch discard after redirect, DMEM timeout and perf counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [0:0] {StRun, StDwait} state_e;

  state_e           state_q, state_d;
  logic             discard_q, discard_d;
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, mem_wb_flush;
  logic load_use;
  logic redirect;

  // Load-use is the only RAW hazard the forwarding unit cannot cover.
  always_comb begin
    load_use = 1'b0;
    if (bus.id_ex_memread && (bus.id_ex_rd != 5'd0)) begin
      load_use = (bus.if_id_use_rs1 && (bus.if_id_rs1 == bus.id_ex_rd)) ||
                 (bus.if_id_use_rs2 && (bus.if_id_rs2 == bus.id_ex_rd));
    end
  end

  // Stage controls: a single priority row wins each cycle.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    discard_d    = discard_q;
    redirect     = 1'b0;

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (bus.dmem_busy) begin
      // Freeze everything up to EX/MEM; a branch in EX waits and is re-evaluated on release.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect    = 1'b1;
      // If the target word is not back yet, the in-flight fetch is stale and must be dropped.
      discard_d   = !bus.imem_ready;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (discard_q && bus.imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      discard_d   = 1'b0;
    end else if (!bus.imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // DMEM wait tracking and counters.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    flush_d   = flush_q;

    if (bus.dmem_busy) begin
      state_d = StDwait;
      if (state_q == StRun) begin
        wait_d = 16'd1;
      end else if (wait_q < TimeoutVal) begin
        wait_d = wait_q + 16'd1;
      end
    end else begin
      state_d = StRun;
      wait_d  = 16'd0;
    end

    if (bus.dmem_busy && (wait_d >= TimeoutVal)) begin
      timeout_d = 1'b1;
    end

    if (!pc_write) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redirect) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      discard_q <= 1'b0;
      wait_q    <= 16'd0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage OTTER core. It issues per-stage write-enables and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, covering load-use stalls, taken-branch redirects, instruction-memory waits and data-memory waits. It tracks stale fetches that must be discarded after a redirect and flags data-memory timeouts. It works alongside the forwarding unit, which handles every RAW hazard except load-use.

Parameters:
TIMEOUT, 255, consecutive DMEM_BUSY cycles before MEM_TIMEOUT sets (valid range 1..65535).
CNT_W, 32, width of the performance counters.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
IF_ID_RS1, IF_ID_RS2  in  5  source registers of the instruction in decode.
IF_ID_USE_RS1, IF_ID_USE_RS2  in  1  decode instruction actually reads RS1/RS2.
ID_EX_RD  in  5  destination register of the instruction in EX.
ID_EX_MEMREAD  in  1  instruction in EX is a load.
EX_BRANCH_TAKEN  in  1  taken branch, JAL or JALR resolved in EX this cycle.
IMEM_READY  in  1  fetch word valid this cycle. IMEM holds its output while PC is unchanged.
DMEM_BUSY  in  1  MEM-stage access not complete this cycle.
PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE  out  1  register load enables.
IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH  out  1  load a NOP bubble into that register.
MEM_TIMEOUT  out  1  sticky data-memory timeout flag.
STALL_COUNT, FLUSH_COUNT  out  CNT_W  performance counters.

Behaviour:
- Reset (RST_N=0, async):
  - state=RUN, discard=0, wait count=0, counters=0, MEM_TIMEOUT=0.
  - All *_WRITE=0 and all *_FLUSH=1 while reset is held.
- State: FSM {RUN, DWAIT} plus a discard flag. Control outputs are combinational from inputs and the discard flag. Only one priority row applies per cycle.
- Default (no row applies): all WRITE=1, all FLUSH=0.
- P1 DMEM_BUSY=1 (freeze):
  - PC/IF_ID/ID_EX/EX_MEM WRITE=0, MEM_WB_FLUSH=1, other flushes 0. Next state DWAIT.
  - EX_BRANCH_TAKEN is ignored; the branch stays in EX and is re-evaluated after release.
- P2 EX_BRANCH_TAKEN=1 (redirect):
  - All WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FLUSH_COUNT+1.
  - discard_next = !IMEM_READY.
- P3 load-use (ID_EX_MEMREAD && ID_EX_RD!=0 && ((USE_RS1 && RS1==RD) || (USE_RS2 && RS2==RD))):
  - PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, remaining writes 1.
- P4 discard=1 && IMEM_READY=1:
  - Stale word dropped: PC_WRITE=0 (PC already holds target), IF_ID_FLUSH=1. discard cleared.
- P5 IMEM_READY=0:
  - PC_WRITE=0, IF_ID_FLUSH=1, rest WRITE=1.
- STALL_COUNT increments on every non-reset cycle with PC_WRITE=0.
- Both counters wrap at 2^CNT_W.
- DWAIT:
  - Wait count increments each DMEM_BUSY cycle, saturating at TIMEOUT.
  - When the count reaches TIMEOUT, MEM_TIMEOUT=1 from the next cycle. MEM_TIMEOUT is cleared only by reset.
  - DMEM_BUSY=0 returns to RUN and zeroes the wait count.
- The discard flag persists through freezes and load-use stalls. It clears only via P4, a P2 redirect with IMEM_READY=1, or reset.

Test Plan:
- Load-use: MEMREAD=1, RD=5, RS1=5, USE_RS1=1 -> PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1, STALL_COUNT 0->1. Same with RD=0, or USE_RS1=0 -> default outputs.
- Branch, IMEM_READY=1 -> PC_WRITE=1, IF_ID_FLUSH=ID_EX_FLUSH=1, FLUSH_COUNT=1, discard stays 0. Next cycle -> default outputs.
- Branch, IMEM_READY=0, READY low 2 more cycles, then high:
  - Low cycles: PC_WRITE=0, IF_ID_FLUSH=1.
  - Ready cycle: PC_WRITE=0, IF_ID_FLUSH=1 (stale word dropped).
  - Following cycle with READY=1 -> defaults.
- DMEM_BUSY=1 for 3 cycles with EX_BRANCH_TAKEN=1 throughout:
  - Busy cycles: freeze outputs, MEM_WB_FLUSH=1, FLUSH_COUNT unchanged, STALL_COUNT+3.
  - BUSY drops -> redirect, FLUSH_COUNT+1.
- TIMEOUT=4, DMEM_BUSY held 5 cycles -> MEM_TIMEOUT=1 after the 4th busy edge. Still 1 after BUSY=0; only reset clears it.
- Assert RST_N=0 mid-DWAIT with discard=1 -> immediately WRITE=0, FLUSH=1, counters 0. On release: RUN, discard=0, MEM_TIMEOUT=0, default outputs with quiet inputs.
